// File: rtl/chunk_shift_buffer.sv
// Chunk-serial operand buffer for the ECC multiplier datapath.
// Loads NUM_CHUNKS chunks at the MSB end into one TOTAL_W word, or takes
// a full word in parallel and streams it back out LSB chunk first.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start_load or par_load; data_out held
// LOAD   | accepting chunks on in_data/in_valid, count = chunks loaded
// FULL   | operand assembled and held until consume
// UNLOAD | presenting data_out[CHUNK_W-1:0] on ser_data, count = remaining

module chunk_shift_buffer #(
    parameter  int CHUNK_W    = 17,
    parameter  int NUM_CHUNKS = 14,
    localparam int TOTAL_W    = CHUNK_W * NUM_CHUNKS,
    localparam int CNT_W      = $clog2(NUM_CHUNKS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_load,
    input  logic               par_load,
    input  logic [TOTAL_W-1:0] par_data,
    input  logic               abort,
    input  logic [CHUNK_W-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               consume,
    output logic [CHUNK_W-1:0] ser_data,
    output logic               ser_valid,
    input  logic               ser_ready,
    output logic [TOTAL_W-1:0] data_out,
    output logic               full,
    output logic               busy,
    output logic [CNT_W-1:0]   count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FULL   = 2'd2,
        UNLOAD = 2'd3
    } state_t;

    state_t state;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_CHUNKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CHUNKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Status flags decode the registered state only, so no input reaches an output.
    assign in_ready  = (state == LOAD);
    assign ser_valid = (state == UNLOAD);
    assign full      = (state == FULL);
    assign busy      = (state != IDLE);
    assign ser_data  = data_out[CHUNK_W-1:0];

    // Sequencer, shift register and chunk counter; rst beats abort beats handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data_out <= '0;
            count    <= '0;
        end else if (abort) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (par_load) begin
                        data_out <= par_data;
                        count    <= CNT_FULL;
                        state    <= UNLOAD;
                    end else if (start_load) begin
                        count <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        data_out <= {in_data, data_out[TOTAL_W-1:CHUNK_W]};
                        count    <= count + CNT_ONE;
                        if (count == CNT_LAST) begin
                            state <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (consume) begin
                        state <= IDLE;
                    end
                end
                UNLOAD: begin
                    if (ser_ready) begin
                        data_out <= {{CHUNK_W{1'b0}}, data_out[TOTAL_W-1:CHUNK_W]};
                        count    <= count - CNT_ONE;
                        if (count == CNT_ONE) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
